// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Holds the grant state encoding and the default watchdog timeout.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_e;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wishbone_if.sv
// 32-bit Wishbone bundle. The master modport drives requests; the slave
// modport drives responses. clk/rst travel with the bundle for attached IP.
interface wishbone (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        input  clk, rst, dat_i, ack, err, rty,
        output cyc, stb, we, adr, sel, dat_o
    );

    modport slave (
        input  clk, rst, cyc, stb, we, adr, sel, dat_o,
        output dat_i, ack, err, rty
    );

endinterface

// File: rtl/wb_arb_wdog.sv
// Saturating stall counter for the arbiter watchdog; expired is high while
// the count sits at TIMEOUT. Used only when WB_ARB2_TIMEOUT_EN is defined.
module wb_arb_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt_en,
    output logic expired
);
    localparam int             WDC_W = $clog2(TIMEOUT + 1);
    localparam logic [WDC_W-1:0] LIMIT = WDC_W'(TIMEOUT);

    logic [WDC_W-1:0] wdc_q;
    logic [WDC_W-1:0] wdc_d;

    // Clear dominates; the count holds at LIMIT rather than wrapping.
    always_comb begin
        wdc_d = wdc_q;
        if (clr) begin
            wdc_d = '0;
        end else if (cnt_en && (wdc_q != LIMIT)) begin
            wdc_d = wdc_q + WDC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdc_q <= '0;
        end else begin
            wdc_q <= wdc_d;
        end
    end

    assign expired = (wdc_q == LIMIT);

endmodule

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter sharing one slave; ownership is
// held per bus cycle. Define WB_ARB2_TIMEOUT_EN to add the stall watchdog.
module wb_arb2
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    wishbone.slave  m0,
    wishbone.slave  m1,
    wishbone.master s
);
    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_q;
    logic       last_d;
    logic       expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Ties in IDLE go to the master that was not granted last; a grant is
    // kept for as long as its owner holds cyc.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = last_q ? G0 : G1;
                end else if (m0.cyc) begin
                    state_d = G0;
                end else if (m1.cyc) begin
                    state_d = G1;
                end
            end
            G0: begin
                if (!m0.cyc) begin
                    state_d = m1.cyc ? G1 : IDLE;
                end
            end
            G1: begin
                if (!m1.cyc) begin
                    state_d = m0.cyc ? G0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == G0) begin
            last_d = 1'b0;
        end else if (state_d == G1) begin
            last_d = 1'b1;
        end
    end

    // Request and response routing; everything not owned reads as zero.
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.adr    = '0;
        s.sel    = '0;
        s.dat_o  = '0;
        m0.dat_i = '0;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m0.rty   = 1'b0;
        m1.dat_i = '0;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m1.rty   = 1'b0;
        case (state_q)
            G0: begin
                s.cyc    = m0.cyc;
                s.stb    = m0.stb & ~expired;
                s.we     = m0.we;
                s.adr    = m0.adr;
                s.sel    = m0.sel;
                s.dat_o  = m0.dat_o;
                m0.dat_i = s.dat_i;
                m0.ack   = s.ack;
                m0.err   = s.err | expired;
                m0.rty   = s.rty;
            end
            G1: begin
                s.cyc    = m1.cyc;
                s.stb    = m1.stb & ~expired;
                s.we     = m1.we;
                s.adr    = m1.adr;
                s.sel    = m1.sel;
                s.dat_o  = m1.dat_o;
                m1.dat_i = s.dat_i;
                m1.ack   = s.ack;
                m1.err   = s.err | expired;
                m1.rty   = s.rty;
            end
            default: ;
        endcase
    end

`ifdef WB_ARB2_TIMEOUT_EN
    logic gnt_stb;
    logic slave_rsp;
    logic wd_cnt_en;
    logic wd_clr;

    // The count restarts whenever ownership changes or the slave answers.
    always_comb begin
        gnt_stb   = 1'b0;
        if (state_q == G0) begin
            gnt_stb = m0.stb;
        end else if (state_q == G1) begin
            gnt_stb = m1.stb;
        end
        slave_rsp = s.ack | s.err | s.rty;
        wd_cnt_en = gnt_stb & ~slave_rsp;
        wd_clr    = (state_q == IDLE) | (state_d != state_q) | slave_rsp | expired;
    end

    wb_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .cnt_en  (wd_cnt_en),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

endmodule
